// File: rtl/snn_spike_count_decoder.sv
// snn_spike_count_decoder: counts spikes on two channels over a fixed window and presents a classification result
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       begin a window (accepted only when idle)
//   spike_a, spike_b            registered spike inputs from the upstream network
//   busy                        window in progress or result pending
//   result_valid, result_ready  result handshake
//   count_a, count_b            saturating spike counts
//   first_a, first_b            sample index of first spike, WINDOW if none
//   winner, tie, no_spike       classification of the final counts
module snn_spike_count_decoder #(
  parameter int WINDOW = 40,
  parameter int CNT_W  = 6,
  parameter int TW     = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             spike_a,
  input  logic             spike_b,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [TW-1:0]    first_a,
  output logic [TW-1:0]    first_b,
  output logic             winner,
  output logic             tie,
  output logic             no_spike
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  state_t state;
  logic [TW-1:0] idx;
  logic [CNT_W-1:0] na, nb;
  // next counts include the current sample so the last edge classifies on final values
  always_comb begin
    na = (spike_a && count_a != '1) ? count_a + CNT_W'(1) : count_a;
    nb = (spike_b && count_b != '1) ? count_b + CNT_W'(1) : count_b;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      count_a      <= '0;
      count_b      <= '0;
      first_a      <= TW'(WINDOW);
      first_b      <= TW'(WINDOW);
      winner       <= 1'b0;
      tie          <= 1'b0;
      no_spike     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= COUNT;
          busy     <= 1'b1;
          idx      <= '0;
          count_a  <= '0;
          count_b  <= '0;
          first_a  <= TW'(WINDOW);
          first_b  <= TW'(WINDOW);
          winner   <= 1'b0;
          tie      <= 1'b0;
          no_spike <= 1'b0;
        end
        COUNT: begin
          count_a <= na;
          count_b <= nb;
          if (spike_a && first_a == TW'(WINDOW)) first_a <= idx;
          if (spike_b && first_b == TW'(WINDOW)) first_b <= idx;
          idx <= idx + TW'(1);
          if (idx == TW'(WINDOW - 1)) begin
            state        <= HOLD;
            result_valid <= 1'b1;
            winner       <= nb > na;
            tie          <= (na == nb) && (na != '0);
            no_spike     <= (na == '0) && (nb == '0);
          end
        end
        HOLD: if (result_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_spike_count_decoder.sv
// tb_snn_spike_count_decoder: randomized self-checking bench against a behavioural window model
module tb_snn_spike_count_decoder;
  localparam int W = 8;
  logic clk = 1'b0, rst, start, spike_a, spike_b, result_ready;
  logic busy4, rv4, w4, t4, n4;
  logic [3:0] ca4, cb4, fa4, fb4;
  logic busy2, rv2, w2, t2, n2;
  logic [1:0] ca2, cb2;
  logic [3:0] fa2, fb2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  snn_spike_count_decoder #(.WINDOW(W), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .spike_a(spike_a), .spike_b(spike_b),
    .busy(busy4), .result_valid(rv4), .result_ready(result_ready),
    .count_a(ca4), .count_b(cb4), .first_a(fa4), .first_b(fb4),
    .winner(w4), .tie(t4), .no_spike(n4));
  snn_spike_count_decoder #(.WINDOW(W), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .spike_a(spike_a), .spike_b(spike_b),
    .busy(busy2), .result_valid(rv2), .result_ready(result_ready),
    .count_a(ca2), .count_b(cb2), .first_a(fa2), .first_b(fb2),
    .winner(w2), .tie(t2), .no_spike(n2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input int maxc,
                                output int ca, output int cb, output int fa, output int fb,
                                output int w, output int t, output int n);
    ca = 0; cb = 0; fa = W; fb = W;
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin ca++; if (fa == W) fa = i; end
      if (b[i]) begin cb++; if (fb == W) fb = i; end
    end
    if (ca > maxc) ca = maxc;
    if (cb > maxc) cb = maxc;
    w = int'(cb > ca);
    t = int'(ca == cb && ca != 0);
    n = int'(ca == 0 && cb == 0);
  endfunction
  task automatic check_res(input string tag, input logic [7:0] a, input logic [7:0] b);
    int ca, cb, fa, fb, w, t, n;
    model(a, b, 15, ca, cb, fa, fb, w, t, n);
    chk({tag, ".v4"}, 32'(rv4), 1);
    chk({tag, ".ca4"}, 32'(ca4), ca);
    chk({tag, ".cb4"}, 32'(cb4), cb);
    chk({tag, ".fa4"}, 32'(fa4), fa);
    chk({tag, ".fb4"}, 32'(fb4), fb);
    chk({tag, ".w4"}, 32'(w4), w);
    chk({tag, ".t4"}, 32'(t4), t);
    chk({tag, ".n4"}, 32'(n4), n);
    model(a, b, 3, ca, cb, fa, fb, w, t, n);
    chk({tag, ".v2"}, 32'(rv2), 1);
    chk({tag, ".ca2"}, 32'(ca2), ca);
    chk({tag, ".cb2"}, 32'(cb2), cb);
    chk({tag, ".fa2"}, 32'(fa2), fa);
    chk({tag, ".fb2"}, 32'(fb2), fb);
    chk({tag, ".w2"}, 32'(w2), w);
    chk({tag, ".t2"}, 32'(t2), t);
    chk({tag, ".n2"}, 32'(n2), n);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, ".busy"}, 32'({busy4, busy2}), 0);
    chk({tag, ".valid"}, 32'({rv4, rv2}), 0);
    chk({tag, ".cnt"}, 32'({ca4, cb4, ca2, cb2}), 0);
    chk({tag, ".first"}, 32'({fa4, fb4, fa2, fb2}), 32'h8888);
    chk({tag, ".cls"}, 32'({w4, t4, n4, w2, t2, n2}), 0);
  endtask
  // called at #1 after an edge with both DUTs idle; ends #1 after the release edge
  task automatic run_window(input string tag, input logic [7:0] a, input logic [7:0] b, input int hold);
    int ca, cb, fa, fb, w, t, n;
    start = 1'b1;
    result_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk({tag, ".busy"}, 32'({busy4, busy2}), 3);
    for (int i = 0; i < W; i++) begin
      spike_a = a[i];
      spike_b = b[i];
      start = 1'($urandom_range(0, 1));
      result_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (i == W - 2) chk({tag, ".early"}, 32'({rv4, rv2}), 0);
    end
    spike_a = 1'b0;
    spike_b = 1'b0;
    check_res(tag, a, b);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      start = ~start;
      @(posedge clk); #1;
      check_res({tag, ".hold"}, a, b);
    end
    result_ready = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, ".rel_valid"}, 32'({rv4, rv2}), 0);
    chk({tag, ".rel_busy"}, 32'({busy4, busy2}), 0);
    model(a, b, 15, ca, cb, fa, fb, w, t, n);
    chk({tag, ".kept"}, 32'({ca4, cb4, fa4, fb4}), 32'({4'(ca), 4'(cb), 4'(fa), 4'(fb)}));
  endtask
  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; spike_a = 1'b0; spike_b = 1'b0; result_ready = 1'b0;
    #1;
    reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    reset_vals("idle");
    run_window("all_a", 8'hFF, 8'h00, 0);
    run_window("mix", 8'b01010101, 8'b11111100, 5);
    run_window("tie", 8'b10101000, 8'b00000111, 2);
    run_window("zero", 8'h00, 8'h00, 0);
    run_window("sat", 8'hFF, 8'hFF, 1);
    for (int k = 0; k < 30; k++)
      run_window("rnd", 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    // asynchronous reset while holding a result
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    spike_a = 1'b1;
    repeat (W) @(posedge clk);
    #2 spike_a = 1'b0;
    chk("hold_pre", 32'(rv4), 1);
    rst = 1'b1;
    #1;
    reset_vals("rst_hold");
    @(posedge clk); #1 rst = 1'b0;
    // asynchronous reset at sample index 4
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spike_a = 1'b1;
      spike_b = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    reset_vals("rst_idx4");
    rst = 1'b0;
    spike_a = 1'b0;
    spike_b = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= rv4 | rv2 | busy4 | busy2;
    end
    chk("abort_quiet", 32'(seen), 0);
    run_window("after_abort", 8'b00110011, 8'b00010001, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
